// File: rtl/rom_filter_sequencer.sv
// rom_filter_sequencer
//   Sequences a streaming filter run. The block walks a sample ROM and
//   enables the filter while the run is active. It writes each filtered
//   result into a result RAM once the filter latency has elapsed. Between
//   runs, a readback address can be stepped up or down.
//
//   Optional feature (macro SEQ_RESTART_EN):
//     defined   - start=1 during RUN restarts the run from c=0
//     undefined - start is ignored during RUN
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   start        level-sampled run request
//   step_up      single-cycle pulse, readback address +1 (IDLE/DONE only)
//   step_down    single-cycle pulse, readback address -1 (IDLE/DONE only)
//   rom_addr     sample ROM address, min(c, NUM_SAMPLES-1) during RUN
//   filt_en      filter clock-enable, high throughout RUN
//   ram_wr_en    result RAM write enable, high in RUN once c >= LAT
//   ram_wr_addr  result RAM write address, c-LAT while writing
//   ram_rd_addr  readback address, wraps modulo 2^ADDR_BITS
//   busy         high in RUN
//   done         high in DONE
//   state_dbg    current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is a level, not a pulse. It is sampled on every rising
// edge in IDLE or DONE, and also in RUN when SEQ_RESTART_EN is defined.
// There is no ready/ack; busy and done report progress.
module rom_filter_sequencer #(
    parameter int N           = 91,
    parameter int ADDR_BITS   = 8,
    parameter int NUM_SAMPLES = 255,
    parameter int LAT         = N / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step_up,
    input  logic                 step_down,
    output logic [ADDR_BITS-1:0] rom_addr,
    output logic                 filt_en,
    output logic                 ram_wr_en,
    output logic [ADDR_BITS-1:0] ram_wr_addr,
    output logic [ADDR_BITS-1:0] ram_rd_addr,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    localparam int LAST = NUM_SAMPLES + LAT - 1;
    localparam int CW   = (LAST < 1) ? 1 : $clog2(LAST + 1);

    localparam logic [CW-1:0] LAST_C     = CW'(LAST);
    localparam logic [CW-1:0] SAMP_END_C = CW'(NUM_SAMPLES - 1);
    localparam logic [CW-1:0] LAT_C      = CW'(LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          c, c_n;
    logic [ADDR_BITS-1:0]   rom_addr_n, ram_wr_addr_n, ram_rd_addr_n;

    // Next state and next counter
    always_comb begin
        state_n = state;
        c_n     = c;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    c_n     = '0;
                end
            end
            RUN: begin
`ifdef SEQ_RESTART_EN
                if (start) begin
                    c_n = '0;
                end else if (c == LAST_C) begin
                    state_n = DONE;
                end else begin
                    c_n = c + 1'b1;
                end
`else
                if (c == LAST_C) begin
                    state_n = DONE;
                end else begin
                    c_n = c + 1'b1;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                c_n     = '0;
            end
        endcase
    end

    // The address registers are loaded from the next counter value. This
    // keeps them aligned with the cycle in which c holds that value. They
    // keep their last value once the run ends.
    always_comb begin
        rom_addr_n    = rom_addr;
        ram_wr_addr_n = ram_wr_addr;
        if (state_n == RUN) begin
            rom_addr_n = (c_n >= SAMP_END_C) ? ADDR_BITS'(SAMP_END_C)
                                             : ADDR_BITS'(c_n);
            if (c_n >= LAT_C) begin
                ram_wr_addr_n = ADDR_BITS'(c_n - LAT_C);
            end
        end
    end

    // Readback stepping is only live while parked. It is also suppressed
    // on the cycle that launches a run, so entering RUN leaves it untouched.
    always_comb begin
        ram_rd_addr_n = ram_rd_addr;
        if ((state == IDLE || state == DONE) && (state_n != RUN)) begin
            if (step_up && !step_down) begin
                ram_rd_addr_n = ram_rd_addr + 1'b1;
            end else if (step_down && !step_up) begin
                ram_rd_addr_n = ram_rd_addr - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            c           <= '0;
            rom_addr    <= '0;
            ram_wr_addr <= '0;
            ram_rd_addr <= '0;
        end else begin
            state       <= state_n;
            c           <= c_n;
            rom_addr    <= rom_addr_n;
            ram_wr_addr <= ram_wr_addr_n;
            ram_rd_addr <= ram_rd_addr_n;
        end
    end

    // Status outputs decode the registered state, so the asynchronous reset
    // clears them at once.
    assign filt_en   = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign ram_wr_en = (state == RUN) && (c >= LAT_C);
    assign state_dbg = state;

endmodule

// File: tb/tb_rom_filter_sequencer.sv
module tb_rom_filter_sequencer;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          step_up = 1'b0;
    logic          step_down = 1'b0;
    logic [AW-1:0] rom_addr, ram_wr_addr, ram_rd_addr;
    logic          filt_en, ram_wr_en, busy, done;
    logic [1:0]    state_dbg;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int run_len   = 0;

    logic [AW-1:0] exp_rom_q[$];
    logic [AW-1:0] exp_wr_q[$];

    rom_filter_sequencer #(
        .N(5), .ADDR_BITS(AW), .NUM_SAMPLES(8), .LAT(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .step_up(step_up), .step_down(step_down),
        .rom_addr(rom_addr), .filt_en(filt_en), .ram_wr_en(ram_wr_en),
        .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // scoreboard monitor: pops an expectation for every busy cycle and write
    always begin
        @(negedge clk);
        if (busy === 1'b1) begin
            run_len++;
            if (exp_rom_q.size() == 0) check("rom_addr_unexpected", 32'(rom_addr), 32'hFFFF);
            else check("rom_addr", 32'(rom_addr), 32'(exp_rom_q.pop_front()));
            check("filt_en_in_run", 32'(filt_en), 32'd1);
        end
        if (ram_wr_en === 1'b1) begin
            if (exp_wr_q.size() == 0) check("wr_unexpected", 32'(ram_wr_addr), 32'hFFFF);
            else check("ram_wr_addr", 32'(ram_wr_addr), 32'(exp_wr_q.pop_front()));
        end
    end

    // driver tasks
    task automatic push_full_run();
        for (int i = 0; i < 10; i++) exp_rom_q.push_back(AW'((i > 7) ? 7 : i));
        for (int i = 0; i < 8; i++) exp_wr_q.push_back(AW'(i));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        run_len = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (done === 1'b1) seen = 1;
            else @(negedge clk);
        end
        if (!seen) check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rom(input logic [AW-1:0] v);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (busy === 1'b1 && rom_addr === v) seen = 1;
            else @(negedge clk);
        end
        if (!seen) check("wait_rom_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_step(input logic up, input logic dn);
        step_up = up;
        step_down = dn;
        @(negedge clk);
        step_up = 1'b0;
        step_down = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", 32'(state_dbg), 32'd0);

        // single run
        push_full_run();
        pulse_start();
        wait_done();
        check("run1_len", 32'(run_len), 32'd10);
        check("run1_done", 32'(done), 32'd1);
        check("run1_busy", 32'(busy), 32'd0);
        check("run1_wr_en_off", 32'(ram_wr_en), 32'd0);
        check("run1_hold_rom", 32'(rom_addr), 32'd7);
        check("run1_hold_wr", 32'(ram_wr_addr), 32'd7);

        // readback stepping in DONE
        check("rd_initial", 32'(ram_rd_addr), 32'd0);
        do_step(1'b0, 1'b1);
        check("rd_wrap_down", 32'(ram_rd_addr), 32'd255);
        do_step(1'b1, 1'b0);
        check("rd_wrap_up", 32'(ram_rd_addr), 32'd0);
        do_step(1'b1, 1'b1);
        check("rd_both", 32'(ram_rd_addr), 32'd0);

        // step ignored during RUN
        push_full_run();
        pulse_start();
        wait_rom(AW'(3));
        do_step(1'b1, 1'b0);
        check("rd_step_in_run", 32'(ram_rd_addr), 32'd0);
        wait_done();
        check("run2_len", 32'(run_len), 32'd10);
        repeat (3) do_step(1'b1, 1'b0);
        check("rd_up3", 32'(ram_rd_addr), 32'd3);

        // asynchronous reset mid-run at c=5
        for (int i = 0; i < 6; i++) exp_rom_q.push_back(AW'(i));
        for (int i = 0; i < 4; i++) exp_wr_q.push_back(AW'(i));
        pulse_start();
        wait_rom(AW'(5));
        #2 rst = 1'b0;
        #1;
        check("arst_state", 32'(state_dbg), 32'd0);
        check("arst_rom", 32'(rom_addr), 32'd0);
        check("arst_wr_addr", 32'(ram_wr_addr), 32'd0);
        check("arst_rd_addr", 32'(ram_rd_addr), 32'd0);
        check("arst_flags", 32'({filt_en, ram_wr_en, busy, done}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        push_full_run();
        pulse_start();
        wait_done();
        check("run_after_rst_len", 32'(run_len), 32'd10);

        // start pulsed at c=4
`ifdef SEQ_RESTART_EN
        for (int i = 0; i < 5; i++) exp_rom_q.push_back(AW'(i));
        for (int i = 0; i < 3; i++) exp_wr_q.push_back(AW'(i));
        push_full_run();
`else
        push_full_run();
`endif
        pulse_start();
        wait_rom(AW'(4));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef SEQ_RESTART_EN
        check("restart_rom0", 32'(rom_addr), 32'd0);
`else
        check("norestart_rom5", 32'(rom_addr), 32'd5);
`endif
        wait_done();
`ifdef SEQ_RESTART_EN
        check("restart_len", 32'(run_len), 32'd15);
`else
        check("norestart_len", 32'(run_len), 32'd10);
`endif
        check("midstart_done", 32'(done), 32'd1);

        // start held through DONE: back-to-back runs
        push_full_run();
        push_full_run();
        pulse_start();
        wait_done();
        check("b2b_first_len", 32'(run_len), 32'd10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_clear", 32'(done), 32'd0);
        check("b2b_rd_kept", 32'(ram_rd_addr), 32'd0);
        wait_done();
        check("b2b_total_len", 32'(run_len), 32'd20);

        // final report
        @(negedge clk);
        check("rom_q_drained", 32'(exp_rom_q.size()), 32'd0);
        check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
